// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared constants and types for the register-file write stage.
//               Holds the default geometry of the register array and the
//               write-entry record carried through the write queue.
// Revision    : 1.0  initial release
// ============================================================================
package regfile_pkg;

  localparam int DATA_W   = 32;  // width of each register
  localparam int NUM_REGS = 32;  // number of architectural registers
  localparam int ADDR_W   = 5;   // register index width, log2(NUM_REGS)
  localparam int ZERO_REG = 0;   // index of the hardwired-zero register
  localparam int QDEPTH   = 2;   // default write-queue depth

  // One queued write request. The address sits in the upper bits so the
  // packed form matches {wr_addr, wr_data}.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_wr_queue.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wr_queue
// Description : Small in-order synchronous FIFO for register write requests.
//               Push and pop may occur on the same edge; pointers wrap modulo
//               DEPTH. Storage is not reset, only the occupancy state is.
// Revision    : 1.0  initial release
//
// Ports
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   push           in   write push_data at the tail (caller guarantees !full)
//   push_data      in   entry to enqueue
//   pop            in   drop the head entry (caller guarantees !empty)
//   head_data      out  oldest entry
//   full / empty   out  occupancy flags
//   count          out  number of valid entries
//   entries_flat   out  (REGFILE_BYPASS_EN only) entries ordered by age,
//                       slot 0 = oldest, slot DEPTH-1 = newest
//   entries_valid  out  (REGFILE_BYPASS_EN only) valid bit per age slot
//
// Configuration macro: REGFILE_BYPASS_EN
// ============================================================================
module regfile_wr_queue
  import regfile_pkg::*;
#(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
`ifdef REGFILE_BYPASS_EN
  ,
  output logic [DEPTH*WIDTH-1:0] entries_flat,
  output logic [DEPTH-1:0]       entries_valid
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = next_ptr(tail_q);
    if (pop)  head_d = next_ptr(head_q);
    // Push and pop together leave the occupancy unchanged.
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= push_data;
  end

  assign head_data = mem_q[head_q];
  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));

`ifdef REGFILE_BYPASS_EN
  for (genvar k = 0; k < DEPTH; k++) begin : g_age
    assign entries_flat[k*WIDTH +: WIDTH] =
      mem_q[PTR_W'((int'(head_q) + k) % DEPTH)];
    assign entries_valid[k] = (CNT_W'(k) < count_q);
  end
`endif

endmodule : regfile_wr_queue
`default_nettype wire

// File: rtl/regfile_write_stage.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_stage
// Description : Write side and storage of the register file. Write requests
//               are accepted over valid/ready into an in-order queue, then
//               committed one per cycle into the register array unless hold
//               is asserted. The whole array is presented as one flat bus.
//               Register 0 always reads as zero.
// Revision    : 1.0  initial release
//
// Ports
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   wr_valid      in   write request valid
//   wr_ready      out  queue can accept a request (depends on count only)
//   wr_addr       in   destination register
//   wr_data       in   write data
//   hold          in   stalls commits; the queue still accepts until full
//   regs_flat     out  register r at bits [r*DATA_W +: DATA_W]
//   commit_valid  out  registered pulse: one register updated this cycle
//   commit_addr   out  index of the register just updated
//   pending       out  queue non-empty
//
// Configuration macro: REGFILE_BYPASS_EN
//   defined   : regs_flat overlays queued writes (newest wins, r0 excluded)
//   undefined : regs_flat shows committed state only
// ============================================================================
module regfile_write_stage
  import regfile_pkg::*;
#(
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int QDEPTH   = regfile_pkg::QDEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       hold,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       commit_valid,
  output logic [ADDR_W-1:0]          commit_addr,
  output logic                       pending
);

  localparam int ENTRY_W = ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(QDEPTH + 1);

  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [CNT_W-1:0]   w_count;
  logic [ENTRY_W-1:0] w_head;
  logic [ADDR_W-1:0]  w_head_addr;
  logic [DATA_W-1:0]  w_head_data;
  logic               w_head_live;

  logic [DATA_W-1:0]  regs_q [NUM_REGS];
  logic [DATA_W-1:0]  regs_d [NUM_REGS];
  logic               commit_valid_q, commit_valid_d;
  logic [ADDR_W-1:0]  commit_addr_q,  commit_addr_d;
  logic [DATA_W-1:0]  w_view [NUM_REGS];

`ifdef REGFILE_BYPASS_EN
  logic [QDEPTH*ENTRY_W-1:0] w_entries;
  logic [QDEPTH-1:0]         w_entries_valid;
`endif

  // Ready is derived from occupancy alone, so a full queue refuses a new
  // request even on an edge where the head is being committed.
  assign wr_ready = !w_full;
  assign w_push   = wr_valid && wr_ready;
  assign w_pop    = !w_empty && !hold;
  assign pending  = !w_empty;

  regfile_wr_queue #(
    .WIDTH (ENTRY_W),
    .DEPTH (QDEPTH),
    .CNT_W (CNT_W)
  ) u_queue (
    .clk           (clk),
    .rst_n         (rst_n),
    .push          (w_push),
    .push_data     ({wr_addr, wr_data}),
    .pop           (w_pop),
    .head_data     (w_head),
    .full          (w_full),
    .empty         (w_empty),
    .count         (w_count)
`ifdef REGFILE_BYPASS_EN
    ,
    .entries_flat  (w_entries),
    .entries_valid (w_entries_valid)
`endif
  );

  assign {w_head_addr, w_head_data} = w_head;
  assign w_head_live = (w_head_addr != ADDR_W'(ZERO_REG));

  // A popped write to r0 is simply dropped and produces no commit pulse.
  always_comb begin
    regs_d         = regs_q;
    commit_valid_d = 1'b0;
    commit_addr_d  = commit_addr_q;
    if (w_pop && w_head_live) begin
      regs_d[w_head_addr] = w_head_data;
      commit_valid_d      = 1'b1;
      commit_addr_d       = w_head_addr;
    end
    regs_d[ZERO_REG] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q         <= '{default: '0};
      commit_valid_q <= 1'b0;
      commit_addr_q  <= '0;
    end else begin
      regs_q         <= regs_d;
      commit_valid_q <= commit_valid_d;
      commit_addr_q  <= commit_addr_d;
    end
  end

  assign commit_valid = commit_valid_q;
  assign commit_addr  = commit_addr_q;

`ifdef REGFILE_BYPASS_EN
  // Walk the queue oldest to newest so the youngest write to a register
  // lands last and wins.
  always_comb begin
    w_view = regs_q;
    for (int k = 0; k < QDEPTH; k++) begin
      if (w_entries_valid[k] &&
          (w_entries[k*ENTRY_W + DATA_W +: ADDR_W] != ADDR_W'(ZERO_REG))) begin
        w_view[w_entries[k*ENTRY_W + DATA_W +: ADDR_W]] =
          w_entries[k*ENTRY_W +: DATA_W];
      end
    end
  end
`else
  assign w_view = regs_q;
`endif

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_flat
    assign regs_flat[r*DATA_W +: DATA_W] = w_view[r];
  end

endmodule : regfile_write_stage
`default_nettype wire

// File: tb/tb_regfile_write_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_write_stage
// Description : Self-checking bench for regfile_write_stage. Accepted writes
//               push their expected commit into a scoreboard queue; a monitor
//               pops and compares on every commit_valid pulse. Directed
//               checks cover reset, hold, r0 discard, ordering and the
//               REGFILE_BYPASS_EN overlay.
// Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_write_stage;
  import regfile_pkg::*;

  logic                       clk;
  logic                       rst_n;
  logic                       wr_valid;
  logic                       wr_ready;
  logic [ADDR_W-1:0]          wr_addr;
  logic [DATA_W-1:0]          wr_data;
  logic                       hold;
  logic [NUM_REGS*DATA_W-1:0] regs_flat;
  logic                       commit_valid;
  logic [ADDR_W-1:0]          commit_addr;
  logic                       pending;

  int n_cmp = 0;
  int n_bad = 0;
  wr_entry_t exp_q[$];

  regfile_write_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .hold         (hold),
    .regs_flat    (regs_flat),
    .commit_valid (commit_valid),
    .commit_addr  (commit_addr),
    .pending      (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] slice(input int r);
    return regs_flat[r*DATA_W +: DATA_W];
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every commit pulse must match the oldest expected.
  always @(negedge clk) begin
    if (rst_n && commit_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected: commit addr %0d with nothing expected",
                 commit_addr);
      end else begin
        wr_entry_t e;
        e = exp_q.pop_front();
        if (commit_addr !== e.addr || slice(int'(commit_addr)) !== e.data) begin
          n_bad++;
          $display("FAIL sb_commit: got r%0d=0x%08h expected r%0d=0x%08h",
                   commit_addr, slice(int'(commit_addr)), e.addr, e.data);
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int guard;
    wr_entry_t e;
    guard    = 0;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    while (!wr_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!wr_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wr_timeout: wr_ready got 0 expected 1 within 50 cycles");
    end
    @(posedge clk);
    if (a != ADDR_W'(ZERO_REG)) begin
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
    end
    #1;
    wr_valid = 1'b0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_entry_t e;
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    hold     = 1'b0;
    step(2);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_commit_valid", 32'(commit_valid), 32'd0);
    rst_n = 1'b1;
    step(1);

    // Single write, no hold: commit one edge after acceptance.
    do_write(5'd5, 32'hDEADBEEF);
    check("a_pending_after_accept", 32'(pending), 32'd1);
    check("a_commit_not_yet", 32'(commit_valid), 32'd0);
    step(1);
    check("a_commit_valid", 32'(commit_valid), 32'd1);
    check("a_commit_addr", 32'(commit_addr), 32'd5);
    check("a_slice5", slice(5), 32'hDEADBEEF);
    check("a_pending_clear", 32'(pending), 32'd0);
    step(1);
    check("a_commit_pulse_ends", 32'(commit_valid), 32'd0);

    // Hold fills the queue; a third write waits; commits drain in order.
    hold = 1'b1;
    do_write(5'd1, 32'h11);
    do_write(5'd2, 32'h22);
    check("b_wr_ready_full", 32'(wr_ready), 32'd0);
    check("b_pending", 32'(pending), 32'd1);
    wr_valid = 1'b1;
    wr_addr  = 5'd3;
    wr_data  = 32'h33;
    step(3);
    check("b_no_commit_on_hold", 32'(commit_valid), 32'd0);
    check("b_still_full", 32'(wr_ready), 32'd0);
`ifdef REGFILE_BYPASS_EN
    check("b_slice1_bypass", slice(1), 32'h11);
    check("b_slice2_bypass", slice(2), 32'h22);
`else
    check("b_slice1_held", slice(1), 32'h0);
    check("b_slice2_held", slice(2), 32'h0);
`endif
    hold = 1'b0;
    step(1);
    check("b_first_commit_valid", 32'(commit_valid), 32'd1);
    check("b_first_commit_addr", 32'(commit_addr), 32'd1);
    check("b_ready_after_pop", 32'(wr_ready), 32'd1);
    @(posedge clk);
    e.addr = 5'd3;
    e.data = 32'h33;
    exp_q.push_back(e);
    #1;
    wr_valid = 1'b0;
    check("b_second_commit_valid", 32'(commit_valid), 32'd1);
    check("b_second_commit_addr", 32'(commit_addr), 32'd2);
    step(1);
    check("b_third_commit_addr", 32'(commit_addr), 32'd3);
    check("b_slice3", slice(3), 32'h33);
    step(1);

    // Write to r0 is accepted and discarded.
    do_write(5'd0, 32'hFFFFFFFF);
    check("c_r0_accepted_pending", 32'(pending), 32'd1);
    step(1);
    check("c_r0_no_commit", 32'(commit_valid), 32'd0);
    check("c_slice0_zero", slice(0), 32'h0);
    check("c_r0_drained", 32'(pending), 32'd0);

    // Same register twice: younger value survives.
    do_write(5'd7, 32'hA);
    do_write(5'd7, 32'hB);
    step(1);
    check("d_commit_addr7", 32'(commit_addr), 32'd7);
    check("d_slice7_younger", slice(7), 32'hB);
    step(1);

    // Held write: visible immediately only with the bypass overlay.
    hold = 1'b1;
    do_write(5'd3, 32'h1234);
`ifdef REGFILE_BYPASS_EN
    check("e_slice3_bypass", slice(3), 32'h1234);
`else
    check("e_slice3_committed_only", slice(3), 32'h33);
`endif
    step(2);
    check("e_no_commit_on_hold", 32'(commit_valid), 32'd0);
    hold = 1'b0;
    step(1);
    check("e_commit_valid", 32'(commit_valid), 32'd1);
    check("e_slice3_final", slice(3), 32'h1234);
    step(1);

    // Reset with two queued entries under hold discards everything.
    hold = 1'b1;
    do_write(5'd9, 32'h99);
    do_write(5'd10, 32'hAA);
    check("f_full_before_reset", 32'(wr_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("f_rst_wr_ready", 32'(wr_ready), 32'd1);
    check("f_rst_pending", 32'(pending), 32'd0);
    check("f_rst_commit_valid", 32'(commit_valid), 32'd0);
    check("f_rst_slice5", slice(5), 32'h0);
    check("f_rst_slice7", slice(7), 32'h0);
    step(1);
    rst_n = 1'b1;
    hold  = 1'b0;
    step(4);
    check("f_no_late_commit_slice9", slice(9), 32'h0);
    check("f_no_late_commit_slice10", slice(10), 32'h0);
    check("f_idle_pending", 32'(pending), 32'd0);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_regfile_write_stage
`default_nettype wire
